// File: rtl/hand_command_filter.sv
// Blob-count debouncer: per-frame popcount (1 cycle) then a registered lock FSM (command 2 cycles after valid_in).
// No backpressure: every valid_in strobe is one frame and is always accepted.
module hand_command_filter #(
  parameter int NUM_BLOBS      = 5,
  parameter int CNT_W          = $clog2(NUM_BLOBS + 1),
  parameter int STABLE_FRAMES  = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter bit EMIT_ZERO      = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [NUM_BLOBS-1:0] data_in,
  output logic [CNT_W-1:0]     count_out,
  output logic                 count_valid_out,
  output logic [CNT_W-1:0]     cmd_out,
  output logic                 cmd_valid_out,
  output logic                 cmd_locked_out
);

  localparam int RUN_W = 8;
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [RUN_W-1:0] STABLE = RUN_W'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic [CNT_W-1:0] w_popcnt;
  logic [CNT_W-1:0] r_count;
  logic             r_count_vld;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cand, w_cand_n;
  logic [RUN_W-1:0] r_run, w_run_n;
  logic             r_last, w_last_n;
  logic [CNT_W-1:0] r_cmd, w_cmd_n;
  logic             r_cmd_vld, w_cmd_vld_n;
  logic             r_locked, w_locked_n;
  logic             w_eval;
  logic             w_issue;
  logic             w_to_fire;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < NUM_BLOBS; i++) begin
      w_popcnt = w_popcnt + CNT_W'(data_in[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count     <= '0;
      r_count_vld <= 1'b0;
    end else begin
      r_count_vld <= valid_in;
      if (valid_in) begin
        r_count <= w_popcnt;
      end
    end
  end

  // Idle counter saturates at the limit so a long silence fires the timeout only once.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      logic [TO_W-1:0] r_to_cnt;
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          r_to_cnt <= '0;
        end else if (valid_in) begin
          r_to_cnt <= '0;
        end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
      assign w_to_fire = !valid_in && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign w_to_fire = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_n   = r_state;
    w_cand_n    = r_cand;
    w_run_n     = r_run;
    w_last_n    = r_last;
    w_cmd_n     = r_cmd;
    w_cmd_vld_n = 1'b0;
    w_locked_n  = r_locked;
    w_eval      = 1'b0;
    w_issue     = 1'b0;
    if (r_count_vld) begin
      case (r_state)
        ST_IDLE: begin
          w_cand_n  = r_count;
          w_run_n   = RUN_W'(1);
          w_state_n = ST_TRACK;
          w_eval    = 1'b1;
        end
        ST_TRACK: begin
          if (r_count == r_cand) begin
            if (r_run < STABLE) begin
              w_run_n = r_run + 1'b1;
            end
          end else begin
            w_cand_n = r_count;
            w_run_n  = RUN_W'(1);
          end
          w_eval = 1'b1;
        end
        ST_LOCKED: begin
          if (r_count != r_cand) begin
            w_cand_n   = r_count;
            w_run_n    = RUN_W'(1);
            w_state_n  = ST_TRACK;
            w_locked_n = 1'b0;
            w_eval     = 1'b1;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
      if (w_eval && (w_run_n == STABLE)) begin
        w_issue = (!r_last || (w_cand_n != r_cmd)) && (EMIT_ZERO || (w_cand_n != '0));
        // A command due right after a pulse waits in TRACK (run saturated) for the next equal frame.
        if (!(w_issue && r_cmd_vld)) begin
          w_state_n  = ST_LOCKED;
          w_locked_n = 1'b1;
          if (w_issue) begin
            w_cmd_n     = w_cand_n;
            w_cmd_vld_n = 1'b1;
            w_last_n    = 1'b1;
          end
        end else begin
          w_state_n = ST_TRACK;
        end
      end
    end else if (w_to_fire) begin
      w_state_n  = ST_IDLE;
      w_run_n    = '0;
      w_last_n   = 1'b0;
      w_locked_n = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_cand    <= '0;
      r_run     <= '0;
      r_last    <= 1'b0;
      r_cmd     <= '0;
      r_cmd_vld <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cand    <= w_cand_n;
      r_run     <= w_run_n;
      r_last    <= w_last_n;
      r_cmd     <= w_cmd_n;
      r_cmd_vld <= w_cmd_vld_n;
      r_locked  <= w_locked_n;
    end
  end

  assign count_out       = r_count;
  assign count_valid_out = r_count_vld;
  assign cmd_out         = r_cmd;
  assign cmd_valid_out   = r_cmd_vld;
  assign cmd_locked_out  = r_locked;

endmodule

// File: tb/tb_hand_command_filter.sv
// Bench for hand_command_filter: four parameterisations driven independently, table vectors,
// hand sequences for reset/timeout/STABLE_FRAMES=1, and random frames against a history-based model.
module tb_hand_command_filter;

  logic       clk;
  logic       rst;
  logic       v[4];
  logic [4:0] d[4];
  logic [2:0] cnt[4];
  logic [2:0] cmd[4];
  logic       cv[4];
  logic       mv[4];
  logic       lk[4];
  logic       prev_mv[4];

  int checks = 0;
  int errors = 0;

  hand_command_filter #(.NUM_BLOBS(5), .STABLE_FRAMES(4), .TIMEOUT_CYCLES(0), .EMIT_ZERO(1'b1)) u0 (
    .clk_in(clk), .rst_in(rst), .valid_in(v[0]), .data_in(d[0]), .count_out(cnt[0]),
    .count_valid_out(cv[0]), .cmd_out(cmd[0]), .cmd_valid_out(mv[0]), .cmd_locked_out(lk[0]));
  hand_command_filter #(.NUM_BLOBS(5), .STABLE_FRAMES(4), .TIMEOUT_CYCLES(0), .EMIT_ZERO(1'b0)) u1 (
    .clk_in(clk), .rst_in(rst), .valid_in(v[1]), .data_in(d[1]), .count_out(cnt[1]),
    .count_valid_out(cv[1]), .cmd_out(cmd[1]), .cmd_valid_out(mv[1]), .cmd_locked_out(lk[1]));
  hand_command_filter #(.NUM_BLOBS(5), .STABLE_FRAMES(4), .TIMEOUT_CYCLES(10), .EMIT_ZERO(1'b1)) u2 (
    .clk_in(clk), .rst_in(rst), .valid_in(v[2]), .data_in(d[2]), .count_out(cnt[2]),
    .count_valid_out(cv[2]), .cmd_out(cmd[2]), .cmd_valid_out(mv[2]), .cmd_locked_out(lk[2]));
  hand_command_filter #(.NUM_BLOBS(5), .STABLE_FRAMES(1), .TIMEOUT_CYCLES(0), .EMIT_ZERO(1'b1)) u3 (
    .clk_in(clk), .rst_in(rst), .valid_in(v[3]), .data_in(d[3]), .count_out(cnt[3]),
    .count_valid_out(cv[3]), .cmd_out(cmd[3]), .cmd_valid_out(mv[3]), .cmd_locked_out(lk[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input int k, input string tag, input logic ecv, input logic [2:0] ecnt,
                         input logic emv, input logic [2:0] ecmd, input logic elk);
    chk({tag, ".count_valid"}, cv[k], ecv);
    chk({tag, ".count"}, cnt[k], ecnt);
    chk({tag, ".cmd_valid"}, mv[k], emv);
    chk({tag, ".cmd"}, cmd[k], ecmd);
    chk({tag, ".locked"}, lk[k], elk);
  endtask

  // Never two command pulses on consecutive cycles, on any instance.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst && mv[k]) begin
        checks++;
        if (prev_mv[k]) begin
          errors++;
          $display("FAIL consecutive_pulse inst=%0d actual=1 expected=0", k);
        end
      end
      prev_mv[k] = mv[k];
    end
  end

  task automatic do_reset();
    for (int k = 0; k < 4; k++) begin
      v[k] = 1'b0;
      d[k] = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < 4; k++) v[k] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // n back-to-back frames then two idle cycles; reports pulses seen and the final cmd.
  task automatic run_frames(input int k, input logic [4:0] dd, input int n,
                            output int pulses, output logic [2:0] last_cmd);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      v[k] = 1'b1;
      d[k] = dd;
      @(negedge clk);
      if (mv[k]) pulses++;
    end
    v[k] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mv[k]) pulses++;
    end
    last_cmd = cmd[k];
  endtask

  typedef struct {
    logic       vv;
    logic [4:0] dd;
    logic       ecv;
    logic [2:0] ecnt;
    logic       emv;
    logic [2:0] ecmd;
    logic       elk;
  } vec_t;

  function automatic vec_t mk(input logic vv, input logic [4:0] dd, input logic ecv, input logic [2:0] ecnt,
                              input logic emv, input logic [2:0] ecmd, input logic elk);
    vec_t r;
    r.vv = vv; r.dd = dd; r.ecv = ecv; r.ecnt = ecnt; r.emv = emv; r.ecmd = ecmd; r.elk = elk;
    return r;
  endfunction

  // Reference model: a short history of frame counts; a command is due when the
  // trailing run of equal counts has just reached STABLE_FRAMES.
  localparam int MS = 4;
  int         m_hist[$];
  bit         m_last_valid;
  int         m_cmd;
  bit         m_lock;

  task automatic model_clear();
    m_hist.delete();
    m_last_valid = 1'b0;
    m_cmd = 0;
    m_lock = 1'b0;
  endtask

  task automatic model_frame(input int c, output bit issue);
    int  run;
    bit  same;
    m_hist.push_back(c);
    if (m_hist.size() > MS + 1) void'(m_hist.pop_front());
    run = 0;
    same = 1'b1;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (same && m_hist[i] == c) run++;
      else same = 1'b0;
    end
    m_lock = (run >= MS);
    issue = (run == MS) && (!m_last_valid || c != m_cmd);
    if (issue) begin
      m_cmd = c;
      m_last_valid = 1'b1;
    end
  endtask

  localparam logic [4:0] C1  = 5'b01000;
  localparam logic [4:0] C2A = 5'b00011;
  localparam logic [4:0] C2B = 5'b10100;
  localparam logic [4:0] C3  = 5'b10110;
  localparam logic [4:0] C4  = 5'b11011;

  initial begin
    vec_t       tbl[$];
    int         pulses;
    logic [2:0] lc;
    logic       s_v[6];
    logic [4:0] s_d[6];
    logic       s_mv[6];
    logic [2:0] s_cmd[6];
    logic       s_lk[6];
    bit         p_vld;
    int         p_cnt;
    bit         iss;
    bit         nv;
    logic [4:0] nd;
    logic [4:0] last_d;

    for (int k = 0; k < 4; k++) prev_mv[k] = 1'b0;

    // Reset state and single-frame latency
    do_reset();
    chk_all(0, "reset", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    v[0] = 1'b1; d[0] = 5'b10110;
    @(negedge clk);
    chk_all(0, "basic_t1", 1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
    v[0] = 1'b0;
    @(negedge clk);
    chk_all(0, "basic_t2", 1'b0, 3'd3, 1'b0, 3'd0, 1'b0);

    // Debounce, hold, flicker rejection, change and return
    do_reset();
    tbl.push_back(mk(1, C2A, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, C2B, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, C2A, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, C2B, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 2, 1, 2, 1));
    tbl.push_back(mk(1, C2A, 1, 2, 0, 2, 1));
    tbl.push_back(mk(1, C2A, 1, 2, 0, 2, 1));
    tbl.push_back(mk(0, 0,   0, 2, 0, 2, 1));
    tbl.push_back(mk(1, C3,  1, 3, 0, 2, 1));
    tbl.push_back(mk(1, C3,  1, 3, 0, 2, 0));
    tbl.push_back(mk(1, C1,  1, 1, 0, 2, 0));
    tbl.push_back(mk(1, C3,  1, 3, 0, 2, 0));
    tbl.push_back(mk(1, C3,  1, 3, 0, 2, 0));
    tbl.push_back(mk(1, C3,  1, 3, 0, 2, 0));
    tbl.push_back(mk(1, C3,  1, 3, 0, 2, 0));
    tbl.push_back(mk(0, 0,   0, 3, 1, 3, 1));
    tbl.push_back(mk(0, 0,   0, 3, 0, 3, 1));
    tbl.push_back(mk(1, C4,  1, 4, 0, 3, 1));
    tbl.push_back(mk(1, C4,  1, 4, 0, 3, 0));
    tbl.push_back(mk(1, C4,  1, 4, 0, 3, 0));
    tbl.push_back(mk(1, C4,  1, 4, 0, 3, 0));
    tbl.push_back(mk(0, 0,   0, 4, 1, 4, 1));
    tbl.push_back(mk(1, C2B, 1, 2, 0, 4, 1));
    tbl.push_back(mk(1, C2A, 1, 2, 0, 4, 0));
    tbl.push_back(mk(1, C2B, 1, 2, 0, 4, 0));
    tbl.push_back(mk(1, C2A, 1, 2, 0, 4, 0));
    tbl.push_back(mk(0, 0,   0, 2, 1, 2, 1));
    tbl.push_back(mk(0, 0,   0, 2, 0, 2, 1));
    foreach (tbl[i]) begin
      v[0] = tbl[i].vv;
      d[0] = tbl[i].dd;
      @(negedge clk);
      chk_all(0, $sformatf("vec%0d", i), tbl[i].ecv, tbl[i].ecnt, tbl[i].emv, tbl[i].ecmd, tbl[i].elk);
    end

    // Asynchronous reset between edges clears outputs at once
    #2 rst = 1'b1;
    #1 chk_all(0, "async_rst", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after 3 of 4 equal frames discards the partial run
    run_frames(0, C2A, 3, pulses, lc);
    chk("partial_pre_rst.pulses", pulses, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_frames(0, C2A, 3, pulses, lc);
    chk("partial_post3.pulses", pulses, 0);
    run_frames(0, C2A, 1, pulses, lc);
    chk("partial_post4.pulses", pulses, 1);
    chk("partial_post4.cmd", lc, 2);

    // EMIT_ZERO=0: zero count locks silently
    do_reset();
    run_frames(1, 5'b00000, 4, pulses, lc);
    chk("zero.pulses", pulses, 0);
    chk("zero.locked", lk[1], 1);
    chk("zero.cmd", lc, 0);
    run_frames(1, C2B, 4, pulses, lc);
    chk("zero_then2.pulses", pulses, 1);
    chk("zero_then2.cmd", lc, 2);

    // Timeout of 10 idle cycles allows the same gesture again
    do_reset();
    run_frames(2, C1, 4, pulses, lc);
    chk("to_first.pulses", pulses, 1);
    chk("to_first.cmd", lc, 1);
    idle(7);
    chk("to_idle9.locked", lk[2], 1);
    idle(1);
    chk("to_idle10.locked", lk[2], 0);
    chk("to_idle10.cmd", cmd[2], 1);
    run_frames(2, C1, 4, pulses, lc);
    chk("to_again.pulses", pulses, 1);
    chk("to_again.cmd", lc, 1);
    idle(7);
    run_frames(2, C1, 4, pulses, lc);
    chk("to_framewins.pulses", pulses, 0);
    chk("to_framewins.locked", lk[2], 1);

    // STABLE_FRAMES=1, back-to-back 5,5,0
    do_reset();
    s_v   = '{1, 1, 1, 0, 0, 0};
    s_d   = '{5'b11111, 5'b11111, 5'b00000, 5'b0, 5'b0, 5'b0};
    s_mv  = '{0, 1, 0, 1, 0, 0};
    s_cmd = '{0, 5, 5, 0, 0, 0};
    s_lk  = '{0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      v[3] = s_v[i];
      d[3] = s_d[i];
      @(negedge clk);
      chk($sformatf("s1_%0d.cmd_valid", i), mv[3], s_mv[i]);
      chk($sformatf("s1_%0d.cmd", i), cmd[3], s_cmd[i]);
      chk($sformatf("s1_%0d.locked", i), lk[3], s_lk[i]);
    end

    // Random frames on the default instance against the model
    do_reset();
    model_clear();
    p_vld = 1'b0;
    p_cnt = 0;
    last_d = 5'b00000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      nv = ($urandom_range(0, 3) != 0);
      nd = ($urandom_range(0, 9) < 7) ? last_d : 5'($urandom_range(0, 31));
      if (nv) last_d = nd;
      v[0] = nv;
      d[0] = nd;
      iss = 1'b0;
      if (p_vld) model_frame(p_cnt, iss);
      p_vld = nv;
      if (nv) p_cnt = $countones(nd);
      @(negedge clk);
      chk("rnd.count_valid", cv[0], nv);
      chk("rnd.count", cnt[0], p_cnt);
      chk("rnd.cmd_valid", mv[0], iss);
      chk("rnd.cmd", cmd[0], m_cmd);
      chk("rnd.locked", lk[0], m_lock);
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
